// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store engine over a req/ack word memory.
// Aligns store lanes, extends load lanes, and traps misaligned/illegal accesses.
module load_store_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        access_fault_o,
  output logic [31:0] load_data_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, FAULT = 2'd3;
  logic [1:0]  state_q, state_d, off_q;
  logic [2:0]  f3_q;
  logic [3:0]  mem_be_q, be_in;
  logic        mem_we_q, accept, noop, bad;
  logic [31:0] mem_addr_q, mem_wdata_q, wdata_in, load_data_q, load_data_d;
  logic [31:0] shifted, ext;
  logic [15:0] half;
  always_comb begin
    accept   = state_q == IDLE && start_i;
    noop     = !mem_read_i && !mem_write_i;
    bad      = funct3_i == 3'b011 || funct3_i[2:1] == 2'b11 || (mem_write_i && funct3_i[2]) ||
               (funct3_i[1:0] == 2'b01 && alu_result_i[0]) ||
               (funct3_i[1:0] == 2'b10 && alu_result_i[1:0] != 2'b00);
    be_in    = funct3_i[1:0] == 2'b00 ? 4'b0001 << alu_result_i[1:0] :
               funct3_i[1:0] == 2'b01 ? (alu_result_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_in = funct3_i[1:0] == 2'b00 ? {4{store_data_i[7:0]}} :
               funct3_i[1:0] == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
    state_d  = state_q == IDLE   ? (accept ? (noop ? RESP : bad ? FAULT : ACCESS) : IDLE) :
               state_q == ACCESS ? (mem_ack_i ? RESP : ACCESS) : IDLE;
    // funct3[2] marks the unsigned load variants
    shifted  = mem_rdata_i >> {off_q, 3'b000};
    half     = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ext      = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] && shifted[7]}}, shifted[7:0]} :
               f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] && half[15]}}, half} : mem_rdata_i;
    load_data_d = state_q == ACCESS && mem_ack_i && !mem_we_q ? ext : load_data_q;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      f3_q        <= 3'b000;
      mem_be_q    <= 4'b0000;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      mem_be_q    <= state_d == ACCESS ? (accept ? be_in : mem_be_q) : 4'b0000;
      mem_we_q    <= state_d == ACCESS ? (accept ? mem_write_i : mem_we_q) : 1'b0;
      if (accept) begin
        mem_addr_q  <= {alu_result_i[31:2], 2'b00};
        mem_wdata_q <= wdata_in;
        off_q       <= alu_result_i[1:0];
        f3_q        <= funct3_i;
      end
    end
  end
  assign busy_o         = state_q != IDLE;
  assign done_o         = state_q == RESP || state_q == FAULT;
  assign access_fault_o = state_q == FAULT;
  assign mem_req_o      = state_q == ACCESS;
  assign mem_we_o       = mem_we_q;
  assign mem_be_o       = mem_be_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign load_data_o    = load_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenario tasks with hand-computed expectations.
module tb_load_store_unit;
  logic        clk = 0, reset = 1, start = 0, mem_read = 0, mem_write = 0, mem_ack = 0;
  logic [2:0]  funct3 = 0;
  logic [31:0] alu_result = 0, store_data = 0, mem_rdata = 0;
  logic        busy, done, access_fault, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0, failures = 0;

  load_store_unit dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .mem_read_i(mem_read),
    .mem_write_i(mem_write), .funct3_i(funct3), .alu_result_i(alu_result),
    .store_data_i(store_data), .busy_o(busy), .done_o(done),
    .access_fault_o(access_fault), .load_data_o(load_data), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a; store_data = sd; start = 1;
    step();
    start = 0; mem_read = 0; mem_write = 0;
  endtask

  task automatic test_reset();
    checks++; if ({busy, done, access_fault, mem_req, mem_we} !== 5'b0) begin failures++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, access_fault, mem_req, mem_we}); end
    checks++; if ({load_data, mem_addr, mem_wdata, mem_be} !== 100'h0) begin failures++; $display("FAIL reset_data got %h %h %h %h exp 0", load_data, mem_addr, mem_wdata, mem_be); end
    reset = 0;
    step();
  endtask

  task automatic test_reset_mid_access();
    int dones = 0;
    issue(1, 0, 3'b010, 32'h8, 0);
    checks++; if (mem_req !== 1 || busy !== 1 || mem_addr !== 32'h8) begin failures++; $display("FAIL rst_mid_req got req=%b busy=%b addr=%h exp 1 1 00000008", mem_req, busy, mem_addr); end
    @(negedge clk);
    reset = 1;
    #1;
    checks++; if (mem_req !== 0 || busy !== 0) begin failures++; $display("FAIL rst_mid_drop got req=%b busy=%b exp 0 0", mem_req, busy); end
    step();
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      step();
    end
    checks++; if (dones !== 0 || busy !== 0) begin failures++; $display("FAIL rst_mid_nodone got dones=%0d busy=%b exp 0 0", dones, busy); end
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
    mem_rdata = 32'h80FF_1234;
    issue(1, 0, f3, 32'h0000_0103, 0);
    checks++; if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 32'h100 || mem_be !== 4'b1000) begin failures++; $display("FAIL lb_req f3=%b got req=%b we=%b addr=%h be=%b exp 1 0 00000100 1000", f3, mem_req, mem_we, mem_addr, mem_be); end
    mem_ack = 1;
    step();
    mem_ack = 0;
    checks++; if (done !== 1 || access_fault !== 0 || load_data !== exp) begin failures++; $display("FAIL lb_done f3=%b got done=%b flt=%b data=%h exp 1 0 %h", f3, done, access_fault, load_data, exp); end
    step();
    checks++; if (done !== 0 || busy !== 0 || mem_be !== 0) begin failures++; $display("FAIL lb_idle got done=%b busy=%b be=%b exp 0 0 0000", done, busy, mem_be); end
  endtask

  task automatic test_store_half();
    issue(0, 1, 3'b001, 32'h202, 32'hDEAD_BEEF);
    checks++; if (mem_req !== 1 || mem_we !== 1 || mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF || mem_addr !== 32'h200) begin failures++; $display("FAIL sh_req got req=%b we=%b be=%b wd=%h addr=%h exp 1 1 1100 beefbeef 00000200", mem_req, mem_we, mem_be, mem_wdata, mem_addr); end
    mem_ack = 1;
    step();
    mem_ack = 0;
    checks++; if (done !== 1 || access_fault !== 0 || mem_req !== 0 || mem_we !== 0 || mem_be !== 0 || load_data !== 32'h80) begin failures++; $display("FAIL sh_done got done=%b flt=%b req=%b we=%b be=%b ld=%h exp 1 0 0 0 0000 00000080", done, access_fault, mem_req, mem_we, mem_be, load_data); end
    step();
  endtask

  task automatic test_wait_states();
    int reqs = 0;
    mem_rdata = 32'hABCD_0000;
    issue(1, 0, 3'b101, 32'h12, 0);
    for (int i = 0; i < 3; i++) begin
      if (mem_req) reqs++;
      checks++; if (mem_addr !== 32'h10 || mem_be !== 4'b1100 || mem_we !== 0 || busy !== 1) begin failures++; $display("FAIL ws_stable cyc=%0d got addr=%h be=%b we=%b busy=%b exp 00000010 1100 0 1", i, mem_addr, mem_be, mem_we, busy); end
      if (i == 1) begin mem_write = 1; funct3 = 3'b010; alu_result = 32'h40; start = 1; end
      if (i == 2) mem_ack = 1;
      step();
      start = 0; mem_write = 0;
    end
    mem_ack = 0;
    checks++; if (reqs !== 3) begin failures++; $display("FAIL ws_req_cycles got %0d exp 3", reqs); end
    checks++; if (done !== 1 || mem_req !== 0 || load_data !== 32'h0000_ABCD) begin failures++; $display("FAIL ws_done got done=%b req=%b data=%h exp 1 0 0000abcd", done, mem_req, load_data); end
    step();
    step();
    checks++; if (busy !== 0 || mem_req !== 0 || mem_addr !== 32'h10) begin failures++; $display("FAIL ws_start_ignored got busy=%b req=%b addr=%h exp 0 0 00000010", busy, mem_req, mem_addr); end
  endtask

  task automatic test_ack_held();
    int dones = 0, reqs = 0;
    mem_rdata = 32'h1122_3344;
    mem_ack = 1;
    issue(1, 0, 3'b010, 32'h20, 0);
    for (int i = 0; i < 5; i++) begin
      if (done) dones++;
      if (mem_req) reqs++;
      step();
    end
    mem_ack = 0;
    checks++; if (dones !== 1 || reqs !== 1 || load_data !== 32'h1122_3344 || busy !== 0) begin failures++; $display("FAIL ack_held got dones=%0d reqs=%0d data=%h busy=%b exp 1 1 11223344 0", dones, reqs, load_data, busy); end
  endtask

  task automatic test_faults();
    logic [1:0]  ops  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [2:0]  f3s  [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic [31:0] adrs [4] = '{32'h6, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i][1], ops[i][0], f3s[i], adrs[i], 32'hFFFF_FFFF);
      checks++; if (done !== 1 || access_fault !== 1 || mem_req !== 0 || load_data !== 32'h1122_3344) begin failures++; $display("FAIL fault_%0d got done=%b flt=%b req=%b data=%h exp 1 1 0 11223344", i, done, access_fault, mem_req, load_data); end
      step();
      checks++; if (done !== 0 || access_fault !== 0 || busy !== 0 || mem_req !== 0) begin failures++; $display("FAIL fault_%0d_idle got done=%b flt=%b busy=%b req=%b exp 0 0 0 0", i, done, access_fault, busy, mem_req); end
    end
  endtask

  task automatic test_noop_priority();
    issue(0, 0, 3'b010, 32'h44, 0);
    checks++; if (done !== 1 || access_fault !== 0 || mem_req !== 0 || load_data !== 32'h1122_3344) begin failures++; $display("FAIL noop got done=%b flt=%b req=%b data=%h exp 1 0 0 11223344", done, access_fault, mem_req, load_data); end
    step();
    mem_rdata = 32'h5555_5555;
    issue(1, 1, 3'b010, 32'h10, 32'hCAFE_F00D);
    checks++; if (mem_req !== 1 || mem_we !== 1 || mem_be !== 4'b1111 || mem_wdata !== 32'hCAFE_F00D || mem_addr !== 32'h10) begin failures++; $display("FAIL prio_req got req=%b we=%b be=%b wd=%h addr=%h exp 1 1 1111 cafef00d 00000010", mem_req, mem_we, mem_be, mem_wdata, mem_addr); end
    mem_ack = 1;
    step();
    mem_ack = 0;
    checks++; if (done !== 1 || access_fault !== 0 || load_data !== 32'h1122_3344) begin failures++; $display("FAIL prio_done got done=%b flt=%b data=%h exp 1 0 11223344", done, access_fault, load_data); end
    step();
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_reset_mid_access();
    test_load_byte(3'b000, 32'hFFFF_FF80);
    test_load_byte(3'b100, 32'h0000_0080);
    test_store_half();
    test_wait_states();
    test_ack_held();
    test_faults();
    test_noop_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
